board_game_ctrl: RTL and testbench
==================================

BOARD_GAME_CTRL -- requirements
Module: board_game_ctrl

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of players (2..4).
REQ-002 SHALL have parameter BOARD_LEN, default 10, index of the finish square (4..15).
REQ-003 SHALL have parameter DICE_W, default 2, width of dice_value.
REQ-004 SHALL have parameter TICKS_PER_SEC, default 100_000_000, clk cycles per timeout second.
REQ-005 SHALL have parameter TIMEOUT_SEC, default 8, seconds allowed per roll (1..15).
REQ-006 SHALL have parameter EVENT_MASK [BOARD_LEN:0], default squares 2,4,6,8 set, meaning landing square raises an event.
REQ-007 SHALL have parameter RESET_MASK [BOARD_LEN:0], default square 3 set, meaning landing square sends the mover to 0 and raises an event.
REQ-008 SHALL have parameter EXACT_FINISH, default 0, meaning 0 = overshoot clamps to BOARD_LEN and 1 = overshoot forfeits the move.
REQ-009 SHALL define POS_W = clog2(BOARD_LEN+1) and PID_W = clog2(N_PLAYERS).
REQ-010 Ports: clk in 1 system clock; reset in 1 asynchronous active-high reset; start_btn in 1 start/restart request (single-cycle pulse); dice_valid in 1 dice result strobe; dice_value in DICE_W rolled value; event_end_tick in 1 event-handler completion; pos_flat out N_PLAYERS*POS_W player positions, player k at bits [k*POS_W +: POS_W]; turn out PID_W current player; time_left out 4 seconds remaining; timeout_pulse out 1 one-cycle timeout flag; event_valid out 1 one-cycle event flag; event_square out POS_W square that raised the event; winner_valid out 1 game over; winner_id out PID_W winning player.

Function
REQ-011 States SHALL be IDLE, WAIT_DICE, MOVE, CHECK, EVENT, NEXT, WIN.
REQ-012 IDLE: start_btn SHALL clear all positions, set turn=0 and time_left=TIMEOUT_SEC, and go to WAIT_DICE.
REQ-013 WAIT_DICE: dice_valid with dice_value!=0 SHALL latch dice_value and go to MOVE; dice_value==0 SHALL be ignored.
REQ-014 WAIT_DICE: a tick counter SHALL count 0..TICKS_PER_SEC-1; at wrap, time_left SHALL decrement.
REQ-015 When time_left reaches 0, timeout_pulse SHALL be 1 for exactly one cycle and the state SHALL go to NEXT with no position change.
REQ-016 A dice_valid in the same cycle as the final tick SHALL take priority over timeout.
REQ-017 MOVE: sum = pos[turn] + dice, computed at POS_W+1 bits; if sum<=BOARD_LEN, pos[turn] <= sum; otherwise pos[turn] <= BOARD_LEN when EXACT_FINISH=0, and remains unchanged when EXACT_FINISH=1; next state CHECK.
REQ-018 A position SHALL become visible on pos_flat 2 cycles after the dice_valid acceptance cycle.
REQ-019 CHECK SHALL evaluate only the moving player, in this priority: pos==BOARD_LEN goes to WIN; else RESET_MASK[pos] sets pos to 0 and goes to EVENT; else EVENT_MASK[pos] goes to EVENT; else NEXT.
REQ-020 On entry to EVENT, event_valid SHALL pulse for one cycle with event_square = landed square (before any reset to 0).
REQ-021 EVENT SHALL wait for event_end_tick, then go to NEXT; event_end_tick in any other state SHALL be ignored.
REQ-022 NEXT: turn SHALL advance modulo N_PLAYERS (N_PLAYERS-1 wraps to 0), the tick counter SHALL clear, time_left SHALL be set to TIMEOUT_SEC, and the state SHALL go to WAIT_DICE (1 cycle).
REQ-023 WIN: winner_valid=1 and winner_id=mover SHALL be held; start_btn SHALL clear winner_valid, positions, and turn, and go to IDLE.
REQ-024 start_btn SHALL be ignored outside IDLE and WIN; dice_valid SHALL be ignored outside WAIT_DICE.
REQ-025 Other players' positions SHALL never change during a turn.

Reset
REQ-026 While reset is high, state SHALL be IDLE, and pos_flat, turn, timeout_pulse, event_valid, event_square, winner_valid, and winner_id SHALL be 0, with time_left=TIMEOUT_SEC.
REQ-027 Reset asserted mid-turn (any state) SHALL abort immediately to the REQ-026 values; no pulse output SHALL be emitted on release.

Verification (N_PLAYERS=3, BOARD_LEN=10, TICKS_PER_SEC=4, TIMEOUT_SEC=3, default masks)
REQ-028 start, P0 rolls 1 -> pos0=1 two cycles later, no event_valid, turn=1.
REQ-029 P1 rolls 3 -> event_valid with event_square=3, pos1=0; stays in EVENT until event_end_tick; then turn=2.
REQ-030 No dice for 12 cycles in WAIT_DICE -> time_left 3,2,1,0, timeout_pulse once, turn advances, all positions unchanged; after P2 turn, turn wraps to 0.
REQ-031 pos0=9, roll 3: EXACT_FINISH=0 -> pos0=10, winner_valid=1, winner_id=0; EXACT_FINISH=1 -> pos0 stays 9, turn advances.
REQ-032 In WIN, dice_valid and event_end_tick -> no change; start_btn -> IDLE, all outputs cleared; reset pulse during EVENT -> REQ-026 values.

Source files
------------

// File: rtl/board_game_ctrl.sv
// board_game_ctrl
//   Turn-based race game controller. Players take turns rolling a die; the
//   mover advances along a track of squares 0..BOARD_LEN. Some squares raise
//   an event (handled externally, acknowledged by event_end_tick), some send
//   the mover back to square 0. Each roll has a per-turn timeout measured in
//   seconds of TICKS_PER_SEC clock cycles. First player to reach BOARD_LEN wins.
//
// Ports
//   clk            system clock
//   reset          asynchronous active-high reset
//   start_btn      start / restart request (single-cycle pulse)
//   dice_valid     dice result strobe
//   dice_value     rolled value (0 is ignored)
//   event_end_tick event handler completion
//   pos_flat       player positions, player k at [k*POS_W +: POS_W]
//   turn           current player
//   time_left      seconds remaining for the current roll
//   timeout_pulse  one-cycle timeout flag
//   event_valid    one-cycle event flag
//   event_square   square that raised the event
//   winner_valid   game over
//   winner_id      winning player
module board_game_ctrl #(
   parameter int                N_PLAYERS     = 2,
   parameter int                BOARD_LEN     = 10,
   parameter int                DICE_W        = 2,
   parameter int                TICKS_PER_SEC = 100_000_000,
   parameter int                TIMEOUT_SEC   = 8,
   parameter logic [BOARD_LEN:0] EVENT_MASK   = (BOARD_LEN+1)'(16'h0154),
   parameter logic [BOARD_LEN:0] RESET_MASK   = (BOARD_LEN+1)'(16'h0008),
   parameter bit                EXACT_FINISH  = 1'b0,
   parameter int                POS_W         = $clog2(BOARD_LEN+1),
   parameter int                PID_W         = $clog2(N_PLAYERS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start_btn,
   input  logic                         dice_valid,
   input  logic [DICE_W-1:0]            dice_value,
   input  logic                         event_end_tick,
   output logic [N_PLAYERS*POS_W-1:0]   pos_flat,
   output logic [PID_W-1:0]             turn,
   output logic [3:0]                   time_left,
   output logic                         timeout_pulse,
   output logic                         event_valid,
   output logic [POS_W-1:0]             event_square,
   output logic                         winner_valid,
   output logic [PID_W-1:0]             winner_id
);

   localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [3:0]        TIME_INIT = 4'(TIMEOUT_SEC);
   localparam logic [POS_W-1:0]  FINISH    = POS_W'(BOARD_LEN);
   localparam logic [PID_W-1:0]  LAST_PID  = PID_W'(N_PLAYERS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DICE,
      MOVE,
      CHECK,
      EVENT,
      NEXT,
      WIN
   } state_t;

   state_t              state;
   logic [POS_W-1:0]    pos [N_PLAYERS];
   logic [DICE_W-1:0]   dice;
   logic [TICK_W-1:0]   tick;

   logic [POS_W-1:0]    mover_pos;
   logic [POS_W:0]      sum;
   logic [POS_W-1:0]    move_pos;
   logic [PID_W-1:0]    next_turn;

   for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_flat
      assign pos_flat[gi*POS_W +: POS_W] = pos[gi];
   end

   // Position of the player whose turn it is.
   always_comb begin
      mover_pos = '0;
      for (int k = 0; k < N_PLAYERS; k++) begin
         if (turn == PID_W'(k)) begin
            mover_pos = pos[k];
         end
      end
   end

   // One extra bit on the sum so an overshoot past BOARD_LEN is detectable.
   always_comb begin
      sum = {1'b0, mover_pos} + (POS_W+1)'(dice);
      if (sum <= {1'b0, FINISH}) begin
         move_pos = sum[POS_W-1:0];
      end else if (EXACT_FINISH) begin
         move_pos = mover_pos;
      end else begin
         move_pos = FINISH;
      end
   end

   assign next_turn = (turn == LAST_PID) ? '0 : turn + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         for (int k = 0; k < N_PLAYERS; k++) begin
            pos[k] <= '0;
         end
         dice          <= '0;
         tick          <= '0;
         turn          <= '0;
         time_left     <= TIME_INIT;
         timeout_pulse <= 1'b0;
         event_valid   <= 1'b0;
         event_square  <= '0;
         winner_valid  <= 1'b0;
         winner_id     <= '0;
      end else begin
         timeout_pulse <= 1'b0;
         event_valid   <= 1'b0;
         case (state)
            IDLE: begin
               if (start_btn) begin
                  for (int k = 0; k < N_PLAYERS; k++) begin
                     pos[k] <= '0;
                  end
                  turn      <= '0;
                  tick      <= '0;
                  time_left <= TIME_INIT;
                  state     <= WAIT_DICE;
               end
            end
            WAIT_DICE: begin
               // A valid roll wins over a timeout landing in the same cycle.
               if (dice_valid && (dice_value != '0)) begin
                  dice  <= dice_value;
                  state <= MOVE;
               end else if (tick == TICK_LAST) begin
                  tick <= '0;
                  if (time_left <= 4'd1) begin
                     time_left     <= 4'd0;
                     timeout_pulse <= 1'b1;
                     state         <= NEXT;
                  end else begin
                     time_left <= time_left - 4'd1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            MOVE: begin
               for (int k = 0; k < N_PLAYERS; k++) begin
                  if (turn == PID_W'(k)) begin
                     pos[k] <= move_pos;
                  end
               end
               state <= CHECK;
            end
            CHECK: begin
               if (mover_pos == FINISH) begin
                  winner_valid <= 1'b1;
                  winner_id    <= turn;
                  state        <= WIN;
               end else if (RESET_MASK[mover_pos]) begin
                  // Report the landed square, then send the mover home.
                  for (int k = 0; k < N_PLAYERS; k++) begin
                     if (turn == PID_W'(k)) begin
                        pos[k] <= '0;
                     end
                  end
                  event_valid  <= 1'b1;
                  event_square <= mover_pos;
                  state        <= EVENT;
               end else if (EVENT_MASK[mover_pos]) begin
                  event_valid  <= 1'b1;
                  event_square <= mover_pos;
                  state        <= EVENT;
               end else begin
                  state <= NEXT;
               end
            end
            EVENT: begin
               if (event_end_tick) begin
                  state <= NEXT;
               end
            end
            NEXT: begin
               turn      <= next_turn;
               tick      <= '0;
               time_left <= TIME_INIT;
               state     <= WAIT_DICE;
            end
            WIN: begin
               if (start_btn) begin
                  for (int k = 0; k < N_PLAYERS; k++) begin
                     pos[k] <= '0;
                  end
                  turn         <= '0;
                  tick         <= '0;
                  time_left    <= TIME_INIT;
                  winner_valid <= 1'b0;
                  winner_id    <= '0;
                  event_square <= '0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_game_ctrl.sv
// tb_board_game_ctrl
//   Three-player, 10-square game with 4-cycle seconds and a 3-second timeout.
//   Two instances share stimulus: dut0 clamps overshoot, dut1 forfeits it.
//   Each roll pushes its expected outcome to a scoreboard queue; the entry is
//   popped and compared when the DUT resolves the turn.
module tb_board_game_ctrl;

   localparam int NP = 3;
   localparam int PW = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           start_btn;
   logic           dice_valid;
   logic [1:0]     dice_value;
   logic           event_end_tick;

   logic [NP*PW-1:0] pos_flat0, pos_flat1;
   logic [IW-1:0]    turn0, turn1;
   logic [3:0]       time_left0, time_left1;
   logic             timeout_pulse0, timeout_pulse1;
   logic             event_valid0, event_valid1;
   logic [PW-1:0]    event_square0, event_square1;
   logic             winner_valid0, winner_valid1;
   logic [IW-1:0]    winner_id0, winner_id1;

   board_game_ctrl #(
      .N_PLAYERS(3), .BOARD_LEN(10), .DICE_W(2), .TICKS_PER_SEC(4),
      .TIMEOUT_SEC(3), .EXACT_FINISH(1'b0)
   ) dut0 (
      .clk(clk), .reset(reset), .start_btn(start_btn),
      .dice_valid(dice_valid), .dice_value(dice_value),
      .event_end_tick(event_end_tick), .pos_flat(pos_flat0), .turn(turn0),
      .time_left(time_left0), .timeout_pulse(timeout_pulse0),
      .event_valid(event_valid0), .event_square(event_square0),
      .winner_valid(winner_valid0), .winner_id(winner_id0)
   );

   board_game_ctrl #(
      .N_PLAYERS(3), .BOARD_LEN(10), .DICE_W(2), .TICKS_PER_SEC(4),
      .TIMEOUT_SEC(3), .EXACT_FINISH(1'b1)
   ) dut1 (
      .clk(clk), .reset(reset), .start_btn(start_btn),
      .dice_valid(dice_valid), .dice_value(dice_value),
      .event_end_tick(event_end_tick), .pos_flat(pos_flat1), .turn(turn1),
      .time_left(time_left1), .timeout_pulse(timeout_pulse1),
      .event_valid(event_valid1), .event_square(event_square1),
      .winner_valid(winner_valid1), .winner_id(winner_id1)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mover;
      int landed;
      int final_pos;
      int kind;       // 0 = plain move, 1 = event, 2 = win
   } exp_t;

   exp_t sb[$];
   int   m_pos [NP];
   int   m_turn;
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_flat();
      logic [NP*PW-1:0] f;
      for (int k = 0; k < NP; k++) begin
         f[k*PW +: PW] = 4'(m_pos[k]);
      end
      return int'(f);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NP; k++) m_pos[k] = 0;
      m_turn = 0;
   endtask

   // Idle pre_wait cycles in WAIT_DICE, then roll v for the current player.
   task automatic roll(input int v, input int pre_wait);
      exp_t e;
      int   sum;
      for (int i = 0; i < pre_wait; i++) cyc();
      e.mover  = m_turn;
      sum      = m_pos[m_turn] + v;
      e.landed = (sum <= 10) ? sum : 10;
      if (e.landed == 10) begin
         e.kind = 2; e.final_pos = 10;
      end else if (e.landed == 3) begin
         e.kind = 1; e.final_pos = 0;
      end else if (e.landed == 2 || e.landed == 4 || e.landed == 6 || e.landed == 8) begin
         e.kind = 1; e.final_pos = e.landed;
      end else begin
         e.kind = 0; e.final_pos = e.landed;
      end
      sb.push_back(e);

      dice_valid = 1'b1;
      dice_value = 2'(v);
      cyc();                           // acceptance edge
      dice_valid = 1'b0;
      dice_value = 2'd0;
      check_eq("no_timeout_on_accept", int'(timeout_pulse0), 0);
      cyc();                           // MOVE edge: position now visible
      m_pos[e.mover] = e.landed;
      check_eq("pos_after_move", int'(pos_flat0), exp_flat());
      cyc();                           // CHECK edge: outcome visible
      e = sb.pop_front();
      m_pos[e.mover] = e.final_pos;
      $display("roll p%0d +%0d -> landed %0d final %0d kind %0d", e.mover, v,
               e.landed, e.final_pos, e.kind);
      check_eq("event_valid", int'(event_valid0), (e.kind == 1) ? 1 : 0);
      check_eq("winner_valid", int'(winner_valid0), (e.kind == 2) ? 1 : 0);
      check_eq("pos_after_check", int'(pos_flat0), exp_flat());
      if (e.kind == 1) begin
         check_eq("event_square", int'(event_square0), e.landed);
         cyc();
         cyc();
         check_eq("event_one_cycle", int'(event_valid0), 0);
         check_eq("turn_held_in_event", int'(turn0), m_turn);
         event_end_tick = 1'b1;
         cyc();
         event_end_tick = 1'b0;
         cyc();
         m_turn = (m_turn + 1) % NP;
         check_eq("turn_after_event", int'(turn0), m_turn);
         check_eq("time_left_reload", int'(time_left0), 3);
      end else if (e.kind == 0) begin
         cyc();
         m_turn = (m_turn + 1) % NP;
         check_eq("turn_after_move", int'(turn0), m_turn);
         check_eq("time_left_reload", int'(time_left0), 3);
      end else begin
         check_eq("winner_id", int'(winner_id0), e.mover);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset          = 1'b1;
      start_btn      = 1'b0;
      dice_valid     = 1'b0;
      dice_value     = 2'd0;
      event_end_tick = 1'b0;
      model_clear();
      cyc(); cyc(); cyc();
      check_eq("rst_pos", int'(pos_flat0), 0);
      check_eq("rst_turn", int'(turn0), 0);
      check_eq("rst_time_left", int'(time_left0), 3);
      check_eq("rst_timeout", int'(timeout_pulse0), 0);
      check_eq("rst_event", int'(event_valid0), 0);
      check_eq("rst_winner", int'(winner_valid0), 0);
      reset = 1'b0;
      cyc();

      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      check_eq("start_turn", int'(turn0), 0);
      check_eq("start_time_left", int'(time_left0), 3);

      roll(1, 0);     // P0 -> 1, plain
      roll(3, 0);     // P1 -> 3, reset square

      // P2 lets the clock run out; a zero roll and a stray event_end_tick
      // in the middle must not disturb anything.
      for (int i = 1; i <= 12; i++) begin
         dice_valid     = (i == 2);
         event_end_tick = (i == 5);
         cyc();
         dice_valid     = 1'b0;
         event_end_tick = 1'b0;
         if (i == 4)  check_eq("time_left_2", int'(time_left0), 2);
         if (i == 8)  check_eq("time_left_1", int'(time_left0), 1);
         if (i < 12)  check_eq("no_early_timeout", int'(timeout_pulse0), 0);
      end
      check_eq("time_left_0", int'(time_left0), 0);
      check_eq("timeout_pulse", int'(timeout_pulse0), 1);
      check_eq("timeout_pos", int'(pos_flat0), exp_flat());
      cyc();
      m_turn = (m_turn + 1) % NP;
      $display("timeout p2 -> turn %0d", m_turn);
      check_eq("timeout_one_cycle", int'(timeout_pulse0), 0);
      check_eq("turn_wrap", int'(turn0), m_turn);
      check_eq("timeout_reload", int'(time_left0), 3);
      check_eq("timeout_pos_kept", int'(pos_flat0), exp_flat());

      roll(3, 0);     // P0 -> 4 event
      roll(1, 0);     // P1 -> 1
      roll(2, 0);     // P2 -> 2 event
      roll(3, 0);     // P0 -> 7
      roll(2, 0);     // P1 -> 3 reset
      roll(3, 0);     // P2 -> 5
      roll(2, 0);     // P0 -> 9
      roll(1, 11);    // P1 -> 1, roll on the final tick beats the timeout
      roll(1, 0);     // P2 -> 6 event
      roll(3, 0);     // P0 overshoot: dut0 wins at 10

      // Forfeiting instance keeps P0 at 9 and passes the turn.
      check_eq("exact_pos", int'(pos_flat1), int'({4'd6, 4'd1, 4'd9}));
      check_eq("exact_no_win", int'(winner_valid1), 0);
      cyc();
      check_eq("exact_turn", int'(turn1), 1);

      // WIN ignores dice and event acknowledgements.
      dice_valid     = 1'b1;
      dice_value     = 2'd3;
      event_end_tick = 1'b1;
      cyc();
      dice_valid     = 1'b0;
      dice_value     = 2'd0;
      event_end_tick = 1'b0;
      cyc();
      check_eq("win_pos_held", int'(pos_flat0), exp_flat());
      check_eq("win_valid_held", int'(winner_valid0), 1);
      check_eq("win_id_held", int'(winner_id0), 0);
      check_eq("win_no_event", int'(event_valid0), 0);

      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      model_clear();
      $display("restart from WIN");
      check_eq("clr_pos", int'(pos_flat0), exp_flat());
      check_eq("clr_turn", int'(turn0), 0);
      check_eq("clr_winner", int'(winner_valid0), 0);
      check_eq("clr_winner_id", int'(winner_id0), 0);

      // Dice in IDLE are ignored.
      dice_valid = 1'b1;
      dice_value = 2'd2;
      cyc();
      dice_valid = 1'b0;
      cyc(); cyc();
      check_eq("idle_ignores_dice", int'(pos_flat0), 0);

      // New game, P0 lands on an event square, reset hits during EVENT.
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      dice_valid = 1'b1;
      dice_value = 2'd2;
      cyc();
      dice_valid = 1'b0;
      dice_value = 2'd0;
      cyc(); cyc();
      check_eq("pre_reset_event", int'(event_valid0), 1);
      check_eq("pre_reset_pos", int'(pos_flat0), 2);
      #2;
      reset = 1'b1;
      #1;
      $display("reset during EVENT");
      check_eq("async_rst_pos", int'(pos_flat0), 0);
      check_eq("async_rst_event", int'(event_valid0), 0);
      check_eq("async_rst_square", int'(event_square0), 0);
      check_eq("async_rst_time", int'(time_left0), 3);
      cyc();
      reset = 1'b0;
      cyc();
      check_eq("release_event", int'(event_valid0), 0);
      check_eq("release_timeout", int'(timeout_pulse0), 0);
      event_end_tick = 1'b1;
      dice_valid     = 1'b1;
      dice_value     = 2'd1;
      cyc();
      event_end_tick = 1'b0;
      dice_valid     = 1'b0;
      cyc(); cyc();
      check_eq("post_reset_idle_pos", int'(pos_flat0), 0);
      check_eq("post_reset_turn", int'(turn0), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
